// File: rtl/if_redirect_ctrl_pkg.sv
// Shared definitions for the IF redirect controller: state encoding, slot codes, PC width.
package if_redirect_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;

  // Slot in which the branch/jr sits inside the dual-issue bundle
  localparam logic SLOT1 = 1'b0;
  localparam logic SLOT2 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_JR_WAIT = 2'd1,
    ST_DS_WAIT = 2'd2,
    ST_REDIR   = 2'd3
  } state_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/if_redirect_ctrl_if.sv
// Request/response bundle between ID/EX requesters, the redirect controller and IF.
interface if_redirect_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall_i;
  logic              fetch_ack_i;
  logic              exc_req_i;
  logic [ADDR_W-1:0] exc_target_i;
  logic              br_req_i;
  logic              br_slot_i;
  logic [ADDR_W-1:0] br_target_i;
  logic              jr_req_i;
  logic              jr_slot_i;
  logic [ADDR_W-1:0] jr_data_i;
  logic              jr_data_ok_i;

  logic              redirect_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              flush_o;
  logic              kill_slot2_o;
  logic              pc_hold_o;
  logic              addr_err_o;
  logic              busy_o;

  // Requester / pipeline side
  modport master (
    output stall_i, fetch_ack_i, exc_req_i, exc_target_i,
           br_req_i, br_slot_i, br_target_i,
           jr_req_i, jr_slot_i, jr_data_i, jr_data_ok_i,
    input  redirect_o, redirect_pc_o, flush_o, kill_slot2_o,
           pc_hold_o, addr_err_o, busy_o
  );

  // Controller side
  modport slave (
    input  stall_i, fetch_ack_i, exc_req_i, exc_target_i,
           br_req_i, br_slot_i, br_target_i,
           jr_req_i, jr_slot_i, jr_data_i, jr_data_ok_i,
    output redirect_o, redirect_pc_o, flush_o, kill_slot2_o,
           pc_hold_o, addr_err_o, busy_o
  );
endinterface

// File: rtl/if_redirect_ctrl.sv
// Arbitrates exception/branch/jr redirects, honours delay slots and jr operand latency,
// and presents one registered redirect to the IF PC register.
module if_redirect_ctrl
  import if_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input logic               clk,
  input logic               reset,
  if_redirect_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              slot_q, slot_d;
  logic              ds_seen_q, ds_seen_d;

  logic redirect_q, redirect_d;
  logic kill_q, kill_d;
  logic hold_q, hold_d;
  logic busy_q, busy_d;
  logic addr_err_q, addr_err_d;

  // State and datapath registers; outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      slot_q     <= SLOT1;
      ds_seen_q  <= 1'b0;
      redirect_q <= 1'b0;
      kill_q     <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      slot_q     <= slot_d;
      ds_seen_q  <= ds_seen_d;
      redirect_q <= redirect_d;
      kill_q     <= kill_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Next state with fixed priority exc > br > jr; exc overrides any state
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    slot_d    = slot_q;
    ds_seen_d = ds_seen_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.br_req_i) begin
          tgt_d   = bus.br_target_i;
          state_d = (bus.br_slot_i == SLOT2) ? ST_DS_WAIT : ST_REDIR;
        end else if (bus.jr_req_i) begin
          if (bus.jr_data_ok_i) begin
            tgt_d   = bus.jr_data_i;
            state_d = (bus.jr_slot_i == SLOT2) ? ST_DS_WAIT : ST_REDIR;
          end else begin
            state_d   = ST_JR_WAIT;
            slot_d    = bus.jr_slot_i;
            ds_seen_d = 1'b0;
          end
        end
      end
      ST_JR_WAIT: begin
        if (bus.jr_data_ok_i) begin
          tgt_d   = bus.jr_data_i;
          state_d = (slot_q == SLOT1 || ds_seen_q) ? ST_REDIR : ST_DS_WAIT;
        end else if (bus.fetch_ack_i && slot_q == SLOT2) begin
          ds_seen_d = 1'b1;
        end
      end
      ST_DS_WAIT: begin
        if (bus.fetch_ack_i && !bus.stall_i) state_d = ST_REDIR;
      end
      ST_REDIR: begin
        if (!bus.stall_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.exc_req_i) begin
      state_d   = ST_REDIR;
      tgt_d     = bus.exc_target_i;
      ds_seen_d = 1'b0;
    end

    redirect_d = (state_d == ST_REDIR);
    kill_d     = (state_d == ST_DS_WAIT);
    hold_d     = (state_d == ST_JR_WAIT);
    busy_d     = (state_d != ST_IDLE);
    addr_err_d = CHECK_ALIGN && redirect_d && misaligned(tgt_d[1:0]);
  end

  assign bus.redirect_o    = redirect_q;
  assign bus.flush_o       = redirect_q;
  assign bus.redirect_pc_o = tgt_q;
  assign bus.kill_slot2_o  = kill_q;
  assign bus.pc_hold_o     = hold_q;
  assign bus.busy_o        = busy_q;
  assign bus.addr_err_o    = addr_err_q;

endmodule
